// File: rtl/strand_select_stage_pkg.sv
// strand_pkg: shared sizing and constants for the strand issue stage.
package strand_pkg;
  localparam int NUM_STRANDS = 4;
  localparam int STRAND_ID_WIDTH = 2;
  localparam int INSTR_WIDTH = 32;
  localparam int LANE_WIDTH = 4;
  localparam int OFFSET_WIDTH = 32;
  localparam logic [INSTR_WIDTH-1:0] NOP_INSTRUCTION = 32'h0;
endpackage

// File: rtl/strand_select_stage_if.sv
// strand_select_stage_if: strand-side issue handshake plus the registered decode-side slot.
interface strand_select_stage_if #(
  parameter int NUM_STRANDS = strand_pkg::NUM_STRANDS,
  parameter int STRAND_ID_WIDTH = strand_pkg::STRAND_ID_WIDTH
);
  import strand_pkg::*;
  logic [NUM_STRANDS-1:0] issue_request_i;
  logic [INSTR_WIDTH*NUM_STRANDS-1:0] instruction_i;
  logic [32*NUM_STRANDS-1:0] pc_i;
  logic [LANE_WIDTH*NUM_STRANDS-1:0] reg_lane_select_i;
  logic [OFFSET_WIDTH*NUM_STRANDS-1:0] strided_offset_i;
  logic [NUM_STRANDS-1:0] flush_i;
  logic stall_i;
  logic [NUM_STRANDS-1:0] grant_o;
  logic valid_o;
  logic [STRAND_ID_WIDTH-1:0] strand_id_o;
  logic [INSTR_WIDTH-1:0] instruction_o;
  logic [31:0] pc_o;
  logic [LANE_WIDTH-1:0] reg_lane_select_o;
  logic [OFFSET_WIDTH-1:0] strided_offset_o;
  modport master (
    output issue_request_i, instruction_i, pc_i, reg_lane_select_i, strided_offset_i, flush_i, stall_i,
    input grant_o, valid_o, strand_id_o, instruction_o, pc_o, reg_lane_select_o, strided_offset_o
  );
  modport slave (
    input issue_request_i, instruction_i, pc_i, reg_lane_select_i, strided_offset_i, flush_i, stall_i,
    output grant_o, valid_o, strand_id_o, instruction_o, pc_o, reg_lane_select_o, strided_offset_o
  );
endinterface

// File: rtl/strand_select_stage_rr_arbiter.sv
// rr_arbiter: round-robin one-hot grant with a pointer that advances past each winner.
module rr_arbiter #(
  parameter int NUM_STRANDS = strand_pkg::NUM_STRANDS,
  parameter int STRAND_ID_WIDTH = strand_pkg::STRAND_ID_WIDTH
) (
  input  logic clk,
  input  logic reset_n,
  input  logic [NUM_STRANDS-1:0] request_i,
  input  logic enable_i,
  output logic [NUM_STRANDS-1:0] grant_o,
  output logic [STRAND_ID_WIDTH-1:0] grant_id_o
);
  logic [STRAND_ID_WIDTH-1:0] ptr, idx;
  // Scan farthest-to-nearest so the last hit is the one closest to the pointer.
  always_comb begin
    grant_o = '0;
    grant_id_o = '0;
    idx = '0;
    for (int i = NUM_STRANDS - 1; i >= 0; i--) begin
      idx = ptr + STRAND_ID_WIDTH'(i);
      if (enable_i && reset_n && request_i[idx]) begin
        grant_o = '0;
        grant_o[idx] = 1'b1;
        grant_id_o = idx;
      end
    end
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) ptr <= '0;
    else if (|grant_o) ptr <= grant_id_o + STRAND_ID_WIDTH'(1);
endmodule

// File: rtl/strand_select_stage.sv
// strand_select_stage: picks one strand per cycle round-robin and registers its fields for decode.
module strand_select_stage #(
  parameter int NUM_STRANDS = strand_pkg::NUM_STRANDS,
  parameter int STRAND_ID_WIDTH = strand_pkg::STRAND_ID_WIDTH
) (
  input logic clk,
  input logic reset_n,
  strand_select_stage_if.slave bus
);
  import strand_pkg::*;
  logic [NUM_STRANDS-1:0] grant;
  logic [STRAND_ID_WIDTH-1:0] grant_id;
  logic flush_hit;
  rr_arbiter #(.NUM_STRANDS(NUM_STRANDS), .STRAND_ID_WIDTH(STRAND_ID_WIDTH)) u_arb (
    .clk(clk),
    .reset_n(reset_n),
    .request_i(bus.issue_request_i & ~bus.flush_i),
    .enable_i(~bus.stall_i),
    .grant_o(grant),
    .grant_id_o(grant_id)
  );
  assign bus.grant_o = grant;
  assign flush_hit = bus.valid_o && bus.flush_i[bus.strand_id_o];
  // A flush of the held strand turns the slot into a bubble even while decode is stalled.
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      bus.valid_o <= 1'b0;
      bus.strand_id_o <= '0;
      bus.instruction_o <= NOP_INSTRUCTION;
      bus.pc_o <= '0;
      bus.reg_lane_select_o <= '0;
      bus.strided_offset_o <= '0;
    end else if (|grant) begin
      bus.valid_o <= 1'b1;
      bus.strand_id_o <= grant_id;
      bus.instruction_o <= bus.instruction_i[grant_id*INSTR_WIDTH +: INSTR_WIDTH];
      bus.pc_o <= bus.pc_i[grant_id*32 +: 32];
      bus.reg_lane_select_o <= bus.reg_lane_select_i[grant_id*LANE_WIDTH +: LANE_WIDTH];
      bus.strided_offset_o <= bus.strided_offset_i[grant_id*OFFSET_WIDTH +: OFFSET_WIDTH];
    end else if (!bus.stall_i || flush_hit) begin
      bus.valid_o <= 1'b0;
      bus.instruction_o <= NOP_INSTRUCTION;
    end
endmodule

// File: tb/tb_strand_select_stage.sv
// tb_strand_select_stage: random stimulus against a queue-free round-robin reference model.
module tb_strand_select_stage;
  localparam int N = 4;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;
  strand_select_stage_if #(.NUM_STRANDS(N), .STRAND_ID_WIDTH(2)) bus ();
  strand_select_stage #(.NUM_STRANDS(N), .STRAND_ID_WIDTH(2)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));
  logic [N-1:0] req = '0, fl = '0;
  logic st = 1'b0;
  logic [31:0] ins [N], pcs [N], offs [N];
  logic [3:0] lanes [N];
  always_comb begin
    bus.issue_request_i = req;
    bus.flush_i = fl;
    bus.stall_i = st;
    bus.instruction_i = '0;
    bus.pc_i = '0;
    bus.reg_lane_select_i = '0;
    bus.strided_offset_i = '0;
    for (int n = 0; n < N; n++) begin
      bus.instruction_i[32*n +: 32] = ins[n];
      bus.pc_i[32*n +: 32] = pcs[n];
      bus.reg_lane_select_i[4*n +: 4] = lanes[n];
      bus.strided_offset_i[32*n +: 32] = offs[n];
    end
  end
  int total = 0, bad = 0;
  int m_ptr, m_id;
  logic m_valid;
  logic [31:0] m_instr, m_pc, m_off;
  logic [3:0] m_lane;
  logic [N-1:0] eg;
  task automatic m_reset();
    m_ptr = 0; m_id = 0; m_valid = 0; m_instr = 0; m_pc = 0; m_off = 0; m_lane = 0;
  endtask
  function automatic int m_pick();
    if (st) return -1;
    for (int k = 0; k < N; k++) begin
      int j;
      j = (m_ptr + k) % N;
      if (req[j] && !fl[j]) return j;
    end
    return -1;
  endfunction
  function automatic logic [N-1:0] m_gvec();
    logic [N-1:0] v;
    int k;
    v = '0;
    k = m_pick();
    if (k >= 0) v[k] = 1'b1;
    return v;
  endfunction
  task automatic m_tick();
    int k;
    k = m_pick();
    if (k >= 0) begin
      m_valid = 1; m_id = k; m_instr = ins[k]; m_pc = pcs[k]; m_lane = lanes[k]; m_off = offs[k];
      m_ptr = (k + 1) % N;
    end else if (!(st && !(m_valid && fl[m_id]))) begin
      m_valid = 0; m_instr = 0;
    end
  endtask
  task automatic new_data();
    for (int n = 0; n < N; n++) begin
      ins[n] = $urandom; pcs[n] = $urandom; offs[n] = $urandom; lanes[n] = 4'($urandom);
    end
  endtask
  task automatic test_reset();
    new_data();
    req = '1; fl = '0; st = 0; reset_n = 0;
    m_reset();
    #3;
    total++;
    if (bus.grant_o !== 4'b0) begin bad++; $display("FAIL reset_grant got=%b want=0000", bus.grant_o); end
    total++;
    if ({bus.valid_o, bus.strand_id_o, bus.instruction_o, bus.pc_o, bus.reg_lane_select_o, bus.strided_offset_o} !== 103'h0) begin
      bad++; $display("FAIL reset_outputs valid=%b id=%0d instr=%h pc=%h lane=%h off=%h want all zero",
        bus.valid_o, bus.strand_id_o, bus.instruction_o, bus.pc_o, bus.reg_lane_select_o, bus.strided_offset_o);
    end
    @(posedge clk); #1;
    reset_n = 1;
  endtask
  task automatic test_all_request();
    for (int c = 0; c < 8; c++) begin
      new_data(); req = 4'b1111; fl = '0; st = 0;
      #2;
      eg = m_gvec();
      total++;
      if (bus.grant_o !== eg || eg !== 4'(1 << (c % 4))) begin bad++; $display("FAIL all_req_grant c=%0d got=%b want=%b", c, bus.grant_o, 4'(1 << (c % 4))); end
      m_tick();
      @(posedge clk); #1;
      total++;
      if ({bus.valid_o, bus.strand_id_o, bus.instruction_o, bus.pc_o, bus.reg_lane_select_o, bus.strided_offset_o} !== {1'b1, 2'(m_id), m_instr, m_pc, m_lane, m_off})
        begin bad++; $display("FAIL all_req_out c=%0d got v=%b id=%0d i=%h want v=1 id=%0d i=%h", c, bus.valid_o, bus.strand_id_o, bus.instruction_o, m_id, m_instr); end
    end
  endtask
  task automatic test_sparse();
    for (int c = 0; c < 6; c++) begin
      new_data(); req = 4'b1010; fl = '0; st = 0;
      #2;
      eg = m_gvec();
      total++;
      if (bus.grant_o !== eg || (eg !== 4'b0010 && eg !== 4'b1000)) begin bad++; $display("FAIL sparse_grant c=%0d got=%b want=%b", c, bus.grant_o, eg); end
      m_tick();
      @(posedge clk); #1;
      total++;
      if ({bus.valid_o, bus.strand_id_o, bus.instruction_o, bus.pc_o} !== {1'b1, 2'(m_id), m_instr, m_pc})
        begin bad++; $display("FAIL sparse_out c=%0d got id=%0d i=%h want id=%0d i=%h", c, bus.strand_id_o, bus.instruction_o, m_id, m_instr); end
    end
  endtask
  task automatic test_stall(input bit flush_held);
    for (int c = 0; c < 6; c++) begin
      new_data();
      req = (c == 0) ? 4'b0100 : 4'b1111;
      st = (c >= 1 && c <= 3);
      fl = (flush_held && c == 2) ? 4'b0100 : 4'b0000;
      #2;
      eg = m_gvec();
      total++;
      if (bus.grant_o !== eg) begin bad++; $display("FAIL stall_grant f=%0d c=%0d got=%b want=%b", flush_held, c, bus.grant_o, eg); end
      m_tick();
      @(posedge clk); #1;
      total++;
      if (m_valid ? ({bus.valid_o, bus.strand_id_o, bus.instruction_o, bus.pc_o, bus.reg_lane_select_o, bus.strided_offset_o} !== {1'b1, 2'(m_id), m_instr, m_pc, m_lane, m_off})
                  : ({bus.valid_o, bus.instruction_o} !== 33'h0))
        begin bad++; $display("FAIL stall_out f=%0d c=%0d got v=%b id=%0d i=%h want v=%b id=%0d i=%h", flush_held, c, bus.valid_o, bus.strand_id_o, bus.instruction_o, m_valid, m_id, m_instr); end
    end
  endtask
  task automatic test_flush_mask();
    new_data(); req = 4'b0011; fl = 4'b0001; st = 0;
    #2;
    total++;
    if (bus.grant_o !== 4'b0010) begin bad++; $display("FAIL flush_mask got=%b want=0010", bus.grant_o); end
    m_tick();
    @(posedge clk); #1;
  endtask
  task automatic test_random();
    for (int c = 0; c < 200; c++) begin
      new_data();
      req = 4'($urandom); st = ($urandom_range(0, 3) == 0);
      fl = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0;
      #2;
      eg = m_gvec();
      total++;
      if (bus.grant_o !== eg) begin bad++; $display("FAIL rand_grant c=%0d got=%b want=%b", c, bus.grant_o, eg); end
      m_tick();
      @(posedge clk); #1;
      total++;
      if (m_valid ? ({bus.valid_o, bus.strand_id_o, bus.instruction_o, bus.pc_o, bus.reg_lane_select_o, bus.strided_offset_o} !== {1'b1, 2'(m_id), m_instr, m_pc, m_lane, m_off})
                  : ({bus.valid_o, bus.instruction_o} !== 33'h0))
        begin bad++; $display("FAIL rand_out c=%0d got v=%b id=%0d i=%h want v=%b id=%0d i=%h", c, bus.valid_o, bus.strand_id_o, bus.instruction_o, m_valid, m_id, m_instr); end
    end
  endtask
  task automatic test_async_reset();
    for (int c = 0; c < 3; c++) begin
      new_data(); req = 4'b1111; fl = '0; st = 0;
      #2; m_tick();
      @(posedge clk); #1;
    end
    reset_n = 0;
    m_reset();
    #1;
    total++;
    if (bus.valid_o !== 1'b0 || bus.instruction_o !== 32'h0 || bus.grant_o !== 4'b0)
      begin bad++; $display("FAIL async_reset got v=%b i=%h g=%b want v=0 i=0 g=0000", bus.valid_o, bus.instruction_o, bus.grant_o); end
    @(posedge clk); #1;
    reset_n = 1;
    new_data(); req = 4'b1100;
    #2;
    total++;
    if (bus.grant_o !== 4'b0100) begin bad++; $display("FAIL post_reset_grant got=%b want=0100", bus.grant_o); end
    m_tick();
    @(posedge clk); #1;
    total++;
    if ({bus.valid_o, bus.strand_id_o, bus.instruction_o} !== {1'b1, 2'd2, ins[2]})
      begin bad++; $display("FAIL post_reset_out got v=%b id=%0d i=%h want v=1 id=2 i=%h", bus.valid_o, bus.strand_id_o, bus.instruction_o, ins[2]); end
  endtask
  initial begin
    #1;
    test_reset();
    test_all_request();
    test_sparse();
    test_stall(1'b0);
    test_stall(1'b1);
    test_flush_mask();
    test_random();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
